// File: rtl/vga_scan_gen.sv
// vga_scan_gen: 640x480@60 raster timing from a 50 MHz clock with a divide-by-2
// pixel enable, plus the read address for a 128x96 video RAM shown at 5x5
// replication. Sync and blanking outputs are delayed to line up with the RAM's
// registered data.
module vga_scan_gen #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33,
    parameter int SCALE  = 5
) (
    input  logic        clk,
    input  logic        rst,
    output logic [13:0] addr,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic        frame_start
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int SW    = (SCALE > 1) ? $clog2(SCALE) : 1;

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_VIS_L    = HW'(H_VIS);
    localparam logic [HW-1:0] H_STEP_END = HW'(H_VIS - 1);
    localparam logic [HW-1:0] HS_START   = HW'(H_VIS + H_FP);
    localparam logic [HW-1:0] HS_STOP    = HW'(H_VIS + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_VIS_L    = VW'(V_VIS);
    localparam logic [VW-1:0] V_STEP_END = VW'(V_VIS - 1);
    localparam logic [VW-1:0] VS_START   = VW'(V_VIS + V_FP);
    localparam logic [VW-1:0] VS_STOP    = VW'(V_VIS + V_FP + V_SYNC);
    localparam logic [SW-1:0] SUB_LAST   = SW'(SCALE - 1);

    logic          pix_en_q;
    logic [HW-1:0] hc_q, hc_d;
    logic [VW-1:0] vc_q, vc_d;
    logic [SW-1:0] col_sub_q, col_sub_d;
    logic [SW-1:0] row_sub_q, row_sub_d;
    logic [6:0]    col_idx_q, col_idx_d;
    logic [6:0]    row_idx_q, row_idx_d;
    logic          wrap_q, wrap_d;

    logic          vis_raw, hs_raw, vs_raw;
    logic [13:0]   addr_raw;

    logic          s1_vis_q, s1_hs_q, s1_vs_q;
    logic [13:0]   addr_q;
    logic          video_on_q, hsync_q, vsync_q, frame_start_q;

    // Next-state of the scan counters; the sub/idx counters only step inside
    // the visible region so the indices stop at 127 / 95 through blanking.
    always_comb begin
        hc_d      = hc_q;
        vc_d      = vc_q;
        col_sub_d = col_sub_q;
        col_idx_d = col_idx_q;
        row_sub_d = row_sub_q;
        row_idx_d = row_idx_q;
        wrap_d    = 1'b0;
        if (pix_en_q) begin
            if (hc_q == H_LAST) begin
                hc_d      = '0;
                col_sub_d = '0;
                col_idx_d = '0;
                if (vc_q == V_LAST) begin
                    vc_d      = '0;
                    row_sub_d = '0;
                    row_idx_d = '0;
                    wrap_d    = 1'b1;
                end else begin
                    vc_d = vc_q + 1'b1;
                    if (vc_q < V_STEP_END) begin
                        if (row_sub_q == SUB_LAST) begin
                            row_sub_d = '0;
                            row_idx_d = row_idx_q + 1'b1;
                        end else begin
                            row_sub_d = row_sub_q + 1'b1;
                        end
                    end
                end
            end else begin
                hc_d = hc_q + 1'b1;
                if (hc_q < H_STEP_END) begin
                    if (col_sub_q == SUB_LAST) begin
                        col_sub_d = '0;
                        col_idx_d = col_idx_q + 1'b1;
                    end else begin
                        col_sub_d = col_sub_q + 1'b1;
                    end
                end
            end
        end
    end

    // Raw visibility, sync and address decode from the current counters.
    always_comb begin
        vis_raw  = (hc_q < H_VIS_L) && (vc_q < V_VIS_L);
        hs_raw   = !((hc_q >= HS_START) && (hc_q < HS_STOP));
        vs_raw   = !((vc_q >= VS_START) && (vc_q < VS_STOP));
        addr_raw = vis_raw ? {row_idx_q, col_idx_q} : 14'd0;
    end

    // Pixel enable and scan counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_en_q  <= 1'b0;
            hc_q      <= '0;
            vc_q      <= '0;
            col_sub_q <= '0;
            col_idx_q <= '0;
            row_sub_q <= '0;
            row_idx_q <= '0;
            wrap_q    <= 1'b0;
        end else begin
            pix_en_q  <= ~pix_en_q;
            hc_q      <= hc_d;
            vc_q      <= vc_d;
            col_sub_q <= col_sub_d;
            col_idx_q <= col_idx_d;
            row_sub_q <= row_sub_d;
            row_idx_q <= row_idx_d;
            wrap_q    <= wrap_d;
        end
    end

    // Stage 1 (address to the RAM) and stage 2 (sync/blank aligned to RAM data).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q        <= '0;
            s1_vis_q      <= 1'b0;
            s1_hs_q       <= 1'b1;
            s1_vs_q       <= 1'b1;
            video_on_q    <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            addr_q        <= addr_raw;
            s1_vis_q      <= vis_raw;
            s1_hs_q       <= hs_raw;
            s1_vs_q       <= vs_raw;
            video_on_q    <= s1_vis_q;
            hsync_q       <= s1_hs_q;
            vsync_q       <= s1_vs_q;
            frame_start_q <= wrap_q;
        end
    end

    assign addr        = addr_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_scan_gen.sv
// tb_vga_scan_gen: full-size instance for line timing and replication, and a
// shrunken-timing instance so whole frames fit in a short run.
module tb_vga_scan_gen;

    typedef struct packed {
        logic [13:0] addr;
        logic        hs;
        logic        vs;
        logic        von;
        logic        fs;
    } exp_t;

    typedef struct {
        int          hc;
        int          vc;
        logic [13:0] addr;
        logic        hs;
        logic        von;
    } vec_t;

    localparam int S_HV = 20, S_HFP = 2, S_HS = 3, S_HBP = 3;
    localparam int S_VV = 15, S_VFP = 2, S_VS = 2, S_VBP = 3;
    localparam int S_FRAME = (S_HV + S_HFP + S_HS + S_HBP) * (S_VV + S_VFP + S_VS + S_VBP);

    logic clk = 1'b0;
    logic rst_full, rst_small;
    logic [13:0] addr_f, addr_s;
    logic hsync_f, vsync_f, von_f, fs_f;
    logic hsync_s, vsync_s, von_s, fs_s;

    int total = 0;
    int bad   = 0;
    int k_full  = 0;
    int k_small = 0;
    exp_t q_full[$];
    exp_t q_small[$];

    always #10 clk = ~clk;

    vga_scan_gen u_full (
        .clk(clk), .rst(rst_full), .addr(addr_f), .hsync(hsync_f),
        .vsync(vsync_f), .video_on(von_f), .frame_start(fs_f)
    );

    vga_scan_gen #(
        .H_VIS(S_HV), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
        .V_VIS(S_VV), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP), .SCALE(5)
    ) u_small (
        .clk(clk), .rst(rst_small), .addr(addr_s), .hsync(hsync_s),
        .vsync(vsync_s), .video_on(von_s), .frame_start(fs_s)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs after k rising edges since reset release, derived by
    // division from the pixel count rather than by replicating counters.
    function automatic exp_t model(input int k, input int hv, input int hfp, input int hsw,
                                   input int hbp, input int vv, input int vfp, input int vsw,
                                   input int vbp, input int sc);
        exp_t e;
        int ht, vt, n, hc, vc;
        ht = hv + hfp + hsw + hbp;
        vt = vv + vfp + vsw + vbp;
        e  = '{addr: 14'd0, hs: 1'b1, vs: 1'b1, von: 1'b0, fs: 1'b0};
        if (k >= 1) begin
            n  = (k - 1) / 2;
            hc = n % ht;
            vc = (n / ht) % vt;
            if (hc < hv && vc < vv) e.addr = 14'((vc / sc) * 128 + hc / sc);
        end
        if (k >= 2) begin
            n  = (k - 2) / 2;
            hc = n % ht;
            vc = (n / ht) % vt;
            e.von = (hc < hv) && (vc < vv);
            e.hs  = !((hc >= hv + hfp) && (hc < hv + hfp + hsw));
            e.vs  = !((vc >= vv + vfp) && (vc < vv + vfp + vsw));
            if (((k - 1) % 2 == 0) && (((k - 1) / 2) % (ht * vt) == 0)) e.fs = 1'b1;
        end
        return e;
    endfunction

    // Push the expectation for each edge as it happens.
    always @(posedge clk) begin
        if (!rst_full) k_full = 0; else k_full = k_full + 1;
        if (!rst_small) k_small = 0; else k_small = k_small + 1;
        q_full.push_back(model(k_full, 640, 16, 96, 48, 480, 10, 2, 33, 5));
        q_small.push_back(model(k_small, S_HV, S_HFP, S_HS, S_HBP, S_VV, S_VFP, S_VS, S_VBP, 5));
    end

    // Pop and compare away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (q_full.size() == 0) begin
            check("sb_full_empty", 32'd0, 32'd1);
        end else begin
            e = q_full.pop_front();
            check("sb_full", 32'({addr_f, hsync_f, vsync_f, von_f, fs_f}), 32'(e));
        end
        if (q_small.size() == 0) begin
            check("sb_small_empty", 32'd0, 32'd1);
        end else begin
            e = q_small.pop_front();
            check("sb_small", 32'({addr_s, hsync_s, vsync_s, von_s, fs_s}), 32'(e));
        end
    end

    initial begin
        vec_t vecs[16];
        int target, guard, cnt, k1, k2;
        logic prev;

        vecs[0]  = '{4,   0,  14'd0,   1'b1, 1'b1};
        vecs[1]  = '{5,   0,  14'd1,   1'b1, 1'b1};
        vecs[2]  = '{10,  0,  14'd2,   1'b1, 1'b1};
        vecs[3]  = '{639, 0,  14'd127, 1'b1, 1'b1};
        vecs[4]  = '{640, 0,  14'd0,   1'b1, 1'b0};
        vecs[5]  = '{655, 0,  14'd0,   1'b1, 1'b0};
        vecs[6]  = '{656, 0,  14'd0,   1'b0, 1'b0};
        vecs[7]  = '{751, 0,  14'd0,   1'b0, 1'b0};
        vecs[8]  = '{752, 0,  14'd0,   1'b1, 1'b0};
        vecs[9]  = '{799, 0,  14'd0,   1'b1, 1'b0};
        vecs[10] = '{0,   1,  14'd0,   1'b1, 1'b1};
        vecs[11] = '{0,   5,  14'd128, 1'b1, 1'b1};
        vecs[12] = '{7,   5,  14'd129, 1'b1, 1'b1};
        vecs[13] = '{639, 9,  14'd255, 1'b1, 1'b1};
        vecs[14] = '{0,   10, 14'd256, 1'b1, 1'b1};
        vecs[15] = '{12,  10, 14'd258, 1'b1, 1'b1};

        rst_full  = 1'b0;
        rst_small = 1'b0;

        // Reset held for just over 100 ns.
        repeat (4) @(negedge clk);
        check("rst_addr", 32'(addr_f), 32'd0);
        check("rst_hsync", 32'(hsync_f), 32'd1);
        check("rst_vsync", 32'(vsync_f), 32'd1);
        check("rst_video_on", 32'(von_f), 32'd0);
        @(negedge clk);
        #3;
        rst_full  = 1'b1;
        rst_small = 1'b1;
        @(negedge clk);
        check("rel_e1_addr", 32'(addr_f), 32'd0);
        check("rel_e1_video_on", 32'(von_f), 32'd0);
        @(negedge clk);
        check("rel_e2_video_on", 32'(von_f), 32'd1);

        // Table of scan positions on the full-size instance.
        for (int i = 0; i < 16; i++) begin
            target = 2 * (vecs[i].vc * 800 + vecs[i].hc) + 1;
            guard  = 0;
            while (k_full < target && guard < 40000) begin
                @(negedge clk);
                guard++;
            end
            check($sformatf("vec%0d_edge", i), 32'(k_full), 32'(target));
            check($sformatf("vec%0d_addr", i), 32'(addr_f), 32'(vecs[i].addr));
            if (vecs[i].hc == 640) check($sformatf("vec%0d_von_lag", i), 32'(von_f), 32'd1);
            @(negedge clk);
            check($sformatf("vec%0d_hsync", i), 32'(hsync_f), 32'(vecs[i].hs));
            check($sformatf("vec%0d_video_on", i), 32'(von_f), 32'(vecs[i].von));
        end

        // hsync pulse width and fall-to-fall period.
        guard = 0;
        prev  = hsync_f;
        @(negedge clk);
        while (!(prev == 1'b1 && hsync_f == 1'b0) && guard < 2000) begin
            prev = hsync_f;
            @(negedge clk);
            guard++;
        end
        check("hsync_fall_found", 32'(hsync_f), 32'd0);
        k1  = k_full;
        cnt = 0;
        while (hsync_f == 1'b0 && cnt < 400) begin
            cnt++;
            @(negedge clk);
        end
        check("hsync_low_clks", 32'(cnt), 32'd192);
        guard = 0;
        prev  = hsync_f;
        while (!(prev == 1'b1 && hsync_f == 1'b0) && guard < 2000) begin
            prev = hsync_f;
            @(negedge clk);
            guard++;
        end
        k2 = k_full;
        check("hsync_period", 32'(k2 - k1), 32'd1600);

        // vsync width on the small instance.
        guard = 0;
        prev  = vsync_s;
        @(negedge clk);
        while (!(prev == 1'b1 && vsync_s == 1'b0) && guard < 3000) begin
            prev = vsync_s;
            @(negedge clk);
            guard++;
        end
        check("vsync_fall_found", 32'(vsync_s), 32'd0);
        cnt = 0;
        while (vsync_s == 1'b0 && cnt < 3000) begin
            cnt++;
            @(negedge clk);
        end
        check("vsync_low_clks", 32'(cnt), 32'(S_VS * 28 * 2));

        // frame_start width and period.
        guard = 0;
        while (fs_s != 1'b1 && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        check("fs_found", 32'(fs_s), 32'd1);
        k1 = k_small;
        @(negedge clk);
        check("fs_width", 32'(fs_s), 32'd0);
        guard = 0;
        while (fs_s != 1'b1 && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        k2 = k_small;
        check("fs_period", 32'(k2 - k1), 32'(S_FRAME * 2));

        // Mid-frame reset at hc=10, vc=8 of the small instance.
        guard = 0;
        while (!((k_small % 2 == 1) && (((k_small - 1) / 2) % S_FRAME == 8 * 28 + 10)) && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        check("mid_addr_before", 32'(addr_s), 32'd130);
        check("mid_von_before", 32'(von_s), 32'd1);
        #3;
        rst_small = 1'b0;
        #1;
        check("mid_rst_addr", 32'(addr_s), 32'd0);
        check("mid_rst_hsync", 32'(hsync_s), 32'd1);
        check("mid_rst_vsync", 32'(vsync_s), 32'd1);
        check("mid_rst_video_on", 32'(von_s), 32'd0);
        check("mid_rst_fs", 32'(fs_s), 32'd0);
        repeat (3) @(negedge clk);
        #3;
        rst_small = 1'b1;
        @(negedge clk);
        check("mid_rel_e1_von", 32'(von_s), 32'd0);
        @(negedge clk);
        check("mid_rel_e2_von", 32'(von_s), 32'd1);
        repeat (11) @(negedge clk);
        check("mid_restart_addr", 32'(addr_s), 32'd1);

        // Let the scoreboard follow the restarted small frame through its wrap.
        repeat (S_FRAME * 2 + 20) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
